// File: rtl/xor_count_bank.sv
// -----------------------------------------------------------------------------
// xor_count_bank
//
// A bank of NCH independent channels. Each channel has:
//   - a toggle bit that flips by In[i] when En[i] is high,
//   - a WIDTH-bit counter that adds STEP when En[i] is high, or loads LoadVal
//     when Load[i] is high. It either wraps or saturates, set by WRAP,
//   - a registered overflow pulse Tc[i], which is high in the cycle the counter
//     shows the wrapped or clamped value,
//   - combinational XOR views of the toggle bits and the counters.
//
// Optional feature: define XCB_UPDOWN_EN to add the Dir input. When Dir[i]=1,
// channel i counts down by STEP. It wraps or clamps to zero, and Tc flags the
// underflow.
//
// Parameters:
//   WIDTH  counter width per channel (1..16)
//   NCH    number of channels (1..8)
//   STEP   increment, 1 .. 2**WIDTH-1
//   WRAP   1 = wrap modulo 2**WIDTH, 0 = saturate
//
// Ports:
//   Clk      clock, all state updates on posedge
//   Reset    synchronous active-high reset (overrides Load and En)
//   En       per-channel count/toggle enable
//   Dir      per-channel count direction, 1 = down (XCB_UPDOWN_EN only)
//   In       per-channel toggle data
//   Load     per-channel counter load strobe (takes priority over En)
//   LoadVal  load values, channel i at [i*WIDTH +: WIDTH]
//   InV      XOR mask applied to the counters for OutVW
//   OutW     In ^ OutR (combinational)
//   OutR     registered toggle state
//   OutVR    registered counters, packed like LoadVal
//   OutVW    OutVR ^ InV (combinational)
//   Tc       registered overflow/underflow pulse
// -----------------------------------------------------------------------------
module xor_count_bank #(
    parameter int WIDTH = 2,
    parameter int NCH   = 2,
    parameter int STEP  = 1,
    parameter int WRAP  = 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NCH-1:0]         En,
`ifdef XCB_UPDOWN_EN
    input  logic [NCH-1:0]         Dir,
`endif
    input  logic [NCH-1:0]         In,
    input  logic [NCH-1:0]         Load,
    input  logic [NCH*WIDTH-1:0]   LoadVal,
    input  logic [NCH*WIDTH-1:0]   InV,
    output logic [NCH-1:0]         OutW,
    output logic [NCH-1:0]         OutR,
    output logic [NCH*WIDTH-1:0]   OutVR,
    output logic [NCH*WIDTH-1:0]   OutVW,
    output logic [NCH-1:0]         Tc
);

    // STEP widened by one bit. The carry out of the add is then the overflow
    // flag, because STEP <= 2**WIDTH-1 keeps the sum below 2**(WIDTH+1).
    localparam logic [WIDTH:0]   StepExt = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] StepW   = StepExt[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MaxVal  = '1;

    for (genvar gi = 0; gi < NCH; gi++) begin : gCh
        logic [WIDTH-1:0] cntReg;
        logic [WIDTH-1:0] cntNext;
        logic             togReg;
        logic             togNext;
        logic             tcReg;
        logic             tcNext;
        logic [WIDTH:0]   upSum;
        logic [WIDTH-1:0] upCnt;
        logic [WIDTH-1:0] stepCnt;
        logic             stepTc;

        assign upSum = {1'b0, cntReg} + StepExt;

        always_comb begin
            upCnt = upSum[WIDTH-1:0];
            if (upSum[WIDTH] && (WRAP == 0)) begin
                upCnt = MaxVal;
            end
            stepCnt = upCnt;
            stepTc  = upSum[WIDTH];
        end

`ifdef XCB_UPDOWN_EN
        logic             dnUnder;
        logic [WIDTH-1:0] dnDiff;
        logic [WIDTH-1:0] dnCnt;

        // The modulo subtraction gives the wrapped value directly.
        // Saturate mode clamps to zero instead.
        assign dnUnder = (cntReg < StepW);
        assign dnDiff  = cntReg - StepW;
        assign dnCnt   = (dnUnder && (WRAP == 0)) ? '0 : dnDiff;
`endif

        // Ternaries rather than if/else, so that an X on En or Load reaches
        // this channel's state in simulation instead of silently choosing a
        // branch.
        always_comb begin
            togNext = En[gi] ? (togReg ^ In[gi]) : togReg;
`ifdef XCB_UPDOWN_EN
            cntNext = Load[gi] ? LoadVal[gi*WIDTH +: WIDTH]
                    : (En[gi] ? (Dir[gi] ? dnCnt : stepCnt) : cntReg);
            tcNext  = Load[gi] ? 1'b0
                    : (En[gi] ? (Dir[gi] ? dnUnder : stepTc) : 1'b0);
`else
            cntNext = Load[gi] ? LoadVal[gi*WIDTH +: WIDTH]
                    : (En[gi] ? stepCnt : cntReg);
            tcNext  = Load[gi] ? 1'b0 : (En[gi] ? stepTc : 1'b0);
`endif
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                cntReg <= '0;
                togReg <= 1'b0;
                tcReg  <= 1'b0;
            end else begin
                cntReg <= cntNext;
                togReg <= togNext;
                tcReg  <= tcNext;
            end
        end

        assign OutVR[gi*WIDTH +: WIDTH] = cntReg;
        assign OutR[gi]                 = togReg;
        assign Tc[gi]                   = tcReg;
    end

    assign OutW  = In ^ OutR;
    assign OutVW = OutVR ^ InV;

endmodule

// File: tb/tb_xor_count_bank.sv
// -----------------------------------------------------------------------------
// Testbench for xor_count_bank. Three instances, all WIDTH=2 and NCH=2, share
// one set of inputs:
//   dut 0: STEP=1, WRAP=1
//   dut 1: STEP=1, WRAP=0
//   dut 2: STEP=3, WRAP=1
// A table of vectors checks dut 0. Short written sequences check saturation,
// STEP=3 and the down count. A random phase then checks all three instances
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_xor_count_bank;

    logic       Clk = 1'b0;
    logic       rst;
    logic [1:0] en, dir, inb, ld;
    logic [3:0] lv, inv;

    logic [1:0] outW  [3];
    logic [1:0] outR  [3];
    logic [1:0] tc    [3];
    logic [3:0] outVR [3];
    logic [3:0] outVW [3];

    int tests  = 0;
    int failed = 0;

    always #5 Clk = ~Clk;

    xor_count_bank #(.WIDTH(2), .NCH(2), .STEP(1), .WRAP(1)) dut0 (
        .Clk(Clk), .Reset(rst), .En(en),
`ifdef XCB_UPDOWN_EN
        .Dir(dir),
`endif
        .In(inb), .Load(ld), .LoadVal(lv), .InV(inv),
        .OutW(outW[0]), .OutR(outR[0]), .OutVR(outVR[0]), .OutVW(outVW[0]), .Tc(tc[0]));

    xor_count_bank #(.WIDTH(2), .NCH(2), .STEP(1), .WRAP(0)) dut1 (
        .Clk(Clk), .Reset(rst), .En(en),
`ifdef XCB_UPDOWN_EN
        .Dir(dir),
`endif
        .In(inb), .Load(ld), .LoadVal(lv), .InV(inv),
        .OutW(outW[1]), .OutR(outR[1]), .OutVR(outVR[1]), .OutVW(outVW[1]), .Tc(tc[1]));

    xor_count_bank #(.WIDTH(2), .NCH(2), .STEP(3), .WRAP(1)) dut2 (
        .Clk(Clk), .Reset(rst), .En(en),
`ifdef XCB_UPDOWN_EN
        .Dir(dir),
`endif
        .In(inb), .Load(ld), .LoadVal(lv), .InV(inv),
        .OutW(outW[2]), .OutR(outR[2]), .OutVR(outVR[2]), .OutVW(outVW[2]), .Tc(tc[2]));

    // ---------------- reference model (plain integer arithmetic) -------------
    int cfgStep [3] = '{1, 1, 3};
    int cfgWrap [3] = '{1, 0, 1};
    int mCnt [3][2];
    int mTog [3][2];
    int mTc  [3][2];

    // Applies the rules for one clock edge, using the inputs that are being
    // driven now.
    task automatic modelEdge();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 2; c++) begin
                int s;
                if (rst) begin
                    mCnt[d][c] = 0; mTog[d][c] = 0; mTc[d][c] = 0;
                end else begin
                    if (en[c]) mTog[d][c] = mTog[d][c] ^ int'(inb[c]);
                    if (ld[c]) begin
                        mCnt[d][c] = int'(lv[c*2 +: 2]);
                        mTc[d][c]  = 0;
                    end else if (en[c] && dir[c]) begin
                        if (mCnt[d][c] < cfgStep[d]) begin
                            mCnt[d][c] = cfgWrap[d] != 0 ? mCnt[d][c] - cfgStep[d] + 4 : 0;
                            mTc[d][c]  = 1;
                        end else begin
                            mCnt[d][c] = mCnt[d][c] - cfgStep[d];
                            mTc[d][c]  = 0;
                        end
                    end else if (en[c]) begin
                        s = mCnt[d][c] + cfgStep[d];
                        if (s > 3) begin
                            mCnt[d][c] = cfgWrap[d] != 0 ? s - 4 : 3;
                            mTc[d][c]  = 1;
                        end else begin
                            mCnt[d][c] = s;
                            mTc[d][c]  = 0;
                        end
                    end else begin
                        mTc[d][c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // The model follows every edge, so the random phase starts in step with
    // the DUTs. Outputs are sampled 1 time unit after the edge.
    task automatic stepClk();
        modelEdge();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [1:0] e, input logic [1:0] i,
                         input logic [1:0] l, input logic [3:0] v, input logic [3:0] m);
        rst = r; en = e; inb = i; ld = l; lv = v; inv = m;
    endtask

    // ---------------- vector table for dut 0 ----------------
    typedef struct {
        logic       r;
        logic [1:0] e, i, l;
        logic [3:0] v, m;
        logic [1:0] eR, eW, eTc;
        logic [3:0] eVR, eVW;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    int satV [5] = '{1, 2, 3, 3, 3};
    int satT [5] = '{0, 0, 0, 1, 1};
    int s3V  [4] = '{3, 2, 1, 0};
    int s3T  [4] = '{0, 1, 1, 1};

    initial begin
        //            r  en     in     ld     lv       inv      eR     eW     eTc    eVR      eVW
        tbl[0]  = '{1'b1, 2'b11, 2'b11, 2'b11, 4'b1111, 4'b1001, 2'b00, 2'b11, 2'b00, 4'b0000, 4'b1001};
        tbl[1]  = '{1'b0, 2'b01, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 4'b0001, 4'b0001};
        tbl[2]  = '{1'b0, 2'b01, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b01, 2'b00, 4'b0010, 4'b0010};
        tbl[3]  = '{1'b0, 2'b01, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 4'b0011, 4'b0011};
        tbl[4]  = '{1'b0, 2'b01, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b00, 2'b01, 2'b01, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b0, 2'b01, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 4'b0001, 4'b0001};
        tbl[6]  = '{1'b0, 2'b01, 2'b01, 2'b01, 4'b0010, 4'b0000, 2'b00, 2'b01, 2'b00, 4'b0010, 4'b0010};
        tbl[7]  = '{1'b0, 2'b00, 2'b10, 2'b00, 4'b0000, 4'b0110, 2'b00, 2'b10, 2'b00, 4'b0010, 4'b0100};
        tbl[8]  = '{1'b0, 2'b10, 2'b10, 2'b10, 4'b1100, 4'b0000, 2'b10, 2'b00, 2'b00, 4'b1110, 4'b1110};
        tbl[9]  = '{1'b0, 2'b10, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b10, 2'b10, 2'b10, 4'b0010, 4'b0010};
        tbl[10] = '{1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b10, 2'b10, 2'b00, 4'b0010, 4'b0010};

        dir = 2'b00;
        drive(1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000);
        #2;

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].r, tbl[k].e, tbl[k].i, tbl[k].l, tbl[k].v, tbl[k].m);
            stepClk();
            $display("[TB] vec %0d: R=%b W=%b VR=%b VW=%b Tc=%b", k,
                     outR[0], outW[0], outVR[0], outVW[0], tc[0]);
            chk($sformatf("vec%0d_OutR", k),  32'(outR[0]),  32'(tbl[k].eR));
            chk($sformatf("vec%0d_OutW", k),  32'(outW[0]),  32'(tbl[k].eW));
            chk($sformatf("vec%0d_Tc", k),    32'(tc[0]),    32'(tbl[k].eTc));
            chk($sformatf("vec%0d_OutVR", k), 32'(outVR[0]), 32'(tbl[k].eVR));
            chk($sformatf("vec%0d_OutVW", k), 32'(outVW[0]), 32'(tbl[k].eVW));
        end

        // Saturate on dut 1, channel 1, with an InV mask of 01 on that channel.
        drive(1'b1, 2'b11, 2'b11, 2'b11, 4'b1111, 4'b0100);
        stepClk();
        chk("sat_reset_VR", 32'(outVR[1]), 32'h0);
        chk("sat_reset_VW", 32'(outVW[1]), 32'h4);
        drive(1'b0, 2'b10, 2'b00, 2'b00, 4'b0000, 4'b0100);
        for (int k = 0; k < 5; k++) begin
            stepClk();
            $display("[TB] sat %0d: VR=%b Tc=%b VW=%b", k, outVR[1], tc[1], outVW[1]);
            chk($sformatf("sat%0d_VR1", k), 32'(outVR[1][3:2]), 32'(satV[k]));
            chk($sformatf("sat%0d_Tc", k),  32'(tc[1]),         32'(satT[k] << 1));
            chk($sformatf("sat%0d_VW1", k), 32'(outVW[1][3:2]), 32'(satV[k] ^ 1));
            chk($sformatf("sat%0d_VR0", k), 32'(outVR[1][1:0]), 32'h0);
        end

        // STEP=3 wrap on dut 2, channel 0.
        drive(1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000);
        stepClk();
        drive(1'b0, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            stepClk();
            $display("[TB] step3 %0d: VR=%b Tc=%b", k, outVR[2], tc[2]);
            chk($sformatf("step3_%0d_VR", k), 32'(outVR[2]), 32'(s3V[k]));
            chk($sformatf("step3_%0d_Tc", k), 32'(tc[2]),    32'(s3T[k]));
        end

`ifdef XCB_UPDOWN_EN
        // Count down from zero: wrap on dut 0, clamp on dut 1.
        drive(1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000);
        stepClk();
        dir = 2'b01;
        drive(1'b0, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b0000);
        stepClk();
        $display("[TB] down 0: VR0=%b Tc0=%b VR1=%b Tc1=%b", outVR[0], tc[0], outVR[1], tc[1]);
        chk("down0_VR_wrap", 32'(outVR[0]), 32'h3);
        chk("down0_Tc_wrap", 32'(tc[0]),    32'h1);
        chk("down0_VR_sat",  32'(outVR[1]), 32'h0);
        chk("down0_Tc_sat",  32'(tc[1]),    32'h1);
        stepClk();
        $display("[TB] down 1: VR0=%b Tc0=%b", outVR[0], tc[0]);
        chk("down1_VR_wrap", 32'(outVR[0]), 32'h2);
        chk("down1_Tc_wrap", 32'(tc[0]),    32'h0);
        dir = 2'b00;
`endif

        // Random phase: every instance is checked against the model.
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 19) == 0), 2'($urandom), 2'($urandom),
                  (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00),
                  4'($urandom), 4'($urandom));
`ifdef XCB_UPDOWN_EN
            dir = 2'($urandom);
`endif
            stepClk();
            $display("[TB] rnd %0d: r=%b en=%b ld=%b VR=%b/%b/%b Tc=%b/%b/%b", k, rst, en, ld,
                     outVR[0], outVR[1], outVR[2], tc[0], tc[1], tc[2]);
            for (int d = 0; d < 3; d++) begin
                logic [1:0] eR, eT;
                logic [3:0] eV;
                eR = {mTog[d][1][0], mTog[d][0][0]};
                eT = {mTc[d][1][0],  mTc[d][0][0]};
                eV = {2'(mCnt[d][1]), 2'(mCnt[d][0])};
                chk($sformatf("rnd%0d_d%0d_OutR", k, d),  32'(outR[d]),  32'(eR));
                chk($sformatf("rnd%0d_d%0d_OutW", k, d),  32'(outW[d]),  32'(eR ^ inb));
                chk($sformatf("rnd%0d_d%0d_OutVR", k, d), 32'(outVR[d]), 32'(eV));
                chk($sformatf("rnd%0d_d%0d_OutVW", k, d), 32'(outVW[d]), 32'(eV ^ inv));
                chk($sformatf("rnd%0d_d%0d_Tc", k, d),    32'(tc[d]),    32'(eT));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
